uart_wb_loader: RTL and testbench
=================================

Name: uart_wb_loader

Overview:
- UART-to-Wishbone program loader on the port1 side of the dual-port instruction/data memory.
- Receives a raw byte stream on a serial line and packs it into 32-bit little-endian words.
- Issues one single-beat Wishbone write per word at sequential addresses from BASE_ADDR until LOAD_WORDS words are stored, then asserts done_o.
- The core releases from reset on done_o.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; word-aligned.
- LOAD_WORDS, 512, number of 32-bit words to load.
- CNT_W, $clog2(LOAD_WORDS+1), width of word_cnt_o.

Ports:
- wb_clk_i  input  1  clock.
- wb_rst_i  input  1  reset; asynchronous assert, active-low.
- enable_i  input  1  loader enable; low holds receiver idle and clears partial byte/word state.
- rx_i  input  1  UART serial in; asynchronous, idle high.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  write enable; always 1 while wb_cyc_o is 1.
- wb_adr_o  output  32  byte address.
- wb_dat_o  output  32  write data.
- wb_sel_o  output  4  byte select; 4'hF during a cycle.
- wb_ack_i  input  1  slave acknowledge.
- wb_stall_i  input  1  slave stall (pipelined Wishbone).
- wb_err_i  input  1  slave error.
- busy_o  output  1  high from the first start bit accepted until done_o.
- done_o  output  1  sticky; LOAD_WORDS words acknowledged.
- frame_err_o  output  1  sticky; stop bit sampled low.
- overrun_o  output  1  sticky; word completed while the previous write was still pending.
- bus_err_o  output  1  sticky; wb_err_i seen.
- word_cnt_o  output  CNT_W  words completed on the bus.

Behaviour:
- Reset (wb_rst_i=0): all outputs 0, synchroniser flops 1, all FSMs idle.
- rx_i passes through a 2-flop synchroniser, adding 2 cycles of latency.

Receiver FSM: R_IDLE, R_START, R_DATA, R_STOP.
- R_IDLE -> R_START on synchronised rx=0 with enable_i=1 and done_o=0.
- R_START: wait CLKS_PER_BIT/2 cycles, then sample.
  - rx=1: false start, return to R_IDLE.
  - rx=0: go to R_DATA.
- R_DATA: 8 samples, each CLKS_PER_BIT cycles apart, LSB first.
- R_STOP: sample after CLKS_PER_BIT cycles.
  - Sample 1: byte valid.
  - Sample 0: frame_err_o set; byte discarded and byte index unchanged.
  - Either way, return to R_IDLE.
- Valid byte k (k=0..3) goes to word bits [8k+7:8k]. After k=3 the word is loaded into the 1-entry holding register (pending=1) and k returns to 0.
- If the 4th byte completes while pending=1: new word dropped, overrun_o set, k returns to 0.

Bus FSM: B_IDLE, B_REQ, B_WAIT.
- B_IDLE -> B_REQ when pending=1. Drive:
  - cyc=stb=we=1, sel=4'hF
  - adr = BASE_ADDR + 4*word_cnt
  - dat = holding register
- B_REQ: hold all outputs while wb_stall_i=1. Cycle with wb_stall_i=0 is the acceptance; next state B_WAIT with stb=0, cyc=1.
- B_WAIT until wb_ack_i or wb_err_i, then:
  - cyc=we=0, sel=0
  - pending cleared
  - word_cnt incremented
  - wb_err_i sets bus_err_o (the word is not retried)
- An ack in the same cycle as acceptance is not expected; any ack seen in B_REQ is ignored.
- With a 1-cycle registered-ack slave: stb high 1 cycle, ack on the next cycle, cyc high 2 cycles total.
- word_cnt == LOAD_WORDS: done_o=1, busy_o=0. Further bytes are ignored (receiver stays in R_IDLE). done_o clears only on reset.
- enable_i falling mid-byte: receiver returns to R_IDLE, k=0. An in-flight bus cycle still completes.
- adr wraps modulo 2^32.

Test Plan:
- CLKS_PER_BIT=4, LOAD_WORDS=2, BASE_ADDR=32'h1D00; send 0x78,0x56,0x34,0x12 -> one write, adr=32'h1D00, dat=32'h12345678, sel=4'hF, stb high 1 cycle, ack next cycle, word_cnt_o=1.
- Continue with 0xEF,0xBE,0xAD,0xDE -> write adr=32'h1D04, dat=32'hDEADBEEF; done_o=1, busy_o=0; a 9th byte produces no bus activity.
- Stall slave (wb_stall_i=1 for 3 cycles) -> stb/adr/dat held stable 4 cycles; write accepted on cycle 4; exactly one ack counted.
- Byte with stop bit 0 between bytes 1 and 2 -> frame_err_o=1; next 3 good bytes still complete word 0, byte order unshifted.
- 1-cycle low glitch on rx_i (shorter than CLKS_PER_BIT/2) -> no byte received, no error flags.
- Reset asserted mid-B_WAIT -> cyc/stb low immediately (asynchronous); word_cnt_o=0; after release the next 4 bytes write to BASE_ADDR.

Source files
------------

// File: rtl/uart_wb_loader_if.sv
// Pipelined Wishbone write-only link between the UART loader (master) and
// port1 of the instruction/data memory (slave).
interface uart_wb_loader_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output cyc, stb, we, adr, dat, sel,
        input  ack, stall, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat, sel,
        output ack, stall, err
    );
endinterface

// File: rtl/uart_wb_loader.sv
// UART program loader: packs received bytes into little-endian words and
// writes them over Wishbone to sequential addresses; done_o releases the core.
//
// state   | meaning
// R_IDLE  | waiting for a start bit (or loading finished / disabled)
// R_START | half-bit wait, then confirm start bit is still low
// R_DATA  | sampling 8 data bits, LSB first, one per bit period
// R_STOP  | sampling the stop bit; 1 = byte valid, 0 = framing error
// B_IDLE  | no write outstanding
// B_REQ   | stb asserted, waiting for the slave to drop stall
// B_WAIT  | request accepted, waiting for ack or err
module uart_wb_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          LOAD_WORDS   = 512,
    parameter int          CNT_W        = $clog2(LOAD_WORDS + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             enable_i,
    input  logic             rx_i,
    uart_wb_loader_if.master wb,
    output logic             busy_o,
    output logic             done_o,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} bus_state_e;

    rx_state_e        rstate_q, rstate_d;
    bus_state_e       bstate_q, bstate_d;
    logic             rx_s1_q, rx_s2_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       k_q, k_d;
    logic [23:0]      word_q, word_d;
    logic [31:0]      hold_q, hold_d;
    logic             pending_q, pending_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             byte_ok, pend_set, pend_clr, done;

    assign done = (word_cnt_q == CNT_W'(LOAD_WORDS));

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rstate_q    <= R_IDLE;
            bstate_q    <= B_IDLE;
            tmr_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            k_q         <= '0;
            word_q      <= '0;
            hold_q      <= '0;
            pending_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            rx_s1_q     <= rx_i;
            rx_s2_q     <= rx_s1_q;
            rstate_q    <= rstate_d;
            bstate_q    <= bstate_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            k_q         <= k_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            pending_q   <= pending_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            bus_err_q   <= bus_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    always_comb begin
        rstate_d    = rstate_q;
        tmr_d       = tmr_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        k_d         = k_q;
        word_d      = word_q;
        hold_d      = hold_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        busy_d      = busy_q;
        byte_ok     = 1'b0;
        pend_set    = 1'b0;

        case (rstate_q)
            R_IDLE: begin
                if (!rx_s2_q && enable_i && !done) begin
                    rstate_d = R_START;
                    tmr_d    = TMR_HALF;
                    busy_d   = 1'b1;
                end
            end
            R_START: begin
                if (tmr_q == '0) begin
                    if (rx_s2_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rstate_d = R_DATA;
                        tmr_d    = TMR_FULL;
                        bit_d    = 3'd0;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            R_DATA: begin
                if (tmr_q == '0) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    tmr_d   = TMR_FULL;
                    if (bit_q == 3'd7) begin
                        rstate_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            R_STOP: begin
                if (tmr_q == '0) begin
                    rstate_d = R_IDLE;
                    if (rx_s2_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        // The fourth byte goes straight into the holding register with the
        // three already collected; a still-pending word means it is lost.
        if (byte_ok) begin
            k_d = k_q + 2'd1;
            case (k_q)
                2'd0: word_d[7:0]   = shift_q;
                2'd1: word_d[15:8]  = shift_q;
                2'd2: word_d[23:16] = shift_q;
                default: begin
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        hold_d   = {shift_q, word_q};
                        pend_set = 1'b1;
                    end
                end
            endcase
        end

        if (!enable_i) begin
            rstate_d = R_IDLE;
            k_d      = 2'd0;
            word_d   = '0;
            shift_d  = '0;
        end
    end

    always_comb begin
        bstate_d   = bstate_q;
        word_cnt_d = word_cnt_q;
        bus_err_d  = bus_err_q;
        pend_clr   = 1'b0;

        case (bstate_q)
            B_IDLE: begin
                if (pending_q) bstate_d = B_REQ;
            end
            B_REQ: begin
                if (!wb.stall) bstate_d = B_WAIT;
            end
            B_WAIT: begin
                if (wb.ack || wb.err) begin
                    bstate_d   = B_IDLE;
                    pend_clr   = 1'b1;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (wb.err) bus_err_d = 1'b1;
                end
            end
            default: bstate_d = B_IDLE;
        endcase

        pending_d = (pending_q && !pend_clr) || pend_set;
    end

    assign wb.cyc = (bstate_q != B_IDLE);
    assign wb.stb = (bstate_q == B_REQ);
    assign wb.we  = wb.cyc;
    assign wb.sel = wb.cyc ? 4'hF : 4'h0;
    assign wb.adr = wb.cyc ? (BASE_ADDR + (32'(word_cnt_q) << 2)) : 32'h0;
    assign wb.dat = wb.cyc ? hold_q : 32'h0;

    assign busy_o      = busy_q && !done;
    assign done_o      = done;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign bus_err_o   = bus_err_q;
    assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_uart_wb_loader.sv
// Directed bench for uart_wb_loader: UART byte driver, Wishbone slave with
// stall/hold/error knobs, and hand-computed expected writes.
module tb_uart_wb_loader;

    localparam int          CPB  = 4;
    localparam int          LW   = 2;
    localparam logic [31:0] BASE = 32'h1D00;
    localparam int          CW   = $clog2(LW + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          rx = 1'b1;
    logic          busy, done, frame_err, overrun, bus_err;
    logic [CW-1:0] word_cnt;

    uart_wb_loader_if wb_bus();

    uart_wb_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE),
        .LOAD_WORDS  (LW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .enable_i   (enable),
        .rx_i       (rx),
        .wb         (wb_bus),
        .busy_o     (busy),
        .done_o     (done),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .bus_err_o  (bus_err),
        .word_cnt_o (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // slave model state
    int          n_writes = 0;
    int          n_acks = 0;
    int          stall_budget = 0;
    logic        hold_ack = 1'b0;
    logic        err_resp = 1'b0;
    logic        acc = 1'b0;
    int          cur_cyc = 0;
    int          cur_stb = 0;
    int          last_cyc = 0;
    int          last_stb = 0;
    logic        stable_ok = 1'b1;
    logic [31:0] first_adr, first_dat;
    logic [31:0] log_adr [0:15];
    logic [31:0] log_dat [0:15];
    logic [3:0]  log_sel [0:15];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave acts on negedges: stb seen with stall low is accepted on the
    // next posedge, and ack (or err) is driven for the cycle after that.
    initial begin
        wb_bus.ack   = 1'b0;
        wb_bus.err   = 1'b0;
        wb_bus.stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wb_bus.ack   = 1'b0;
                wb_bus.err   = 1'b0;
                wb_bus.stall = 1'b0;
                acc     = 1'b0;
                cur_cyc = 0;
                cur_stb = 0;
                continue;
            end
            wb_bus.ack = 1'b0;
            wb_bus.err = 1'b0;
            if (wb_bus.cyc) cur_cyc++;
            else            cur_cyc = 0;
            if (acc && !hold_ack) begin
                if (err_resp) begin
                    wb_bus.err = 1'b1;
                    err_resp   = 1'b0;
                end else begin
                    wb_bus.ack = 1'b1;
                end
                n_acks++;
                last_cyc = cur_cyc;
                acc = 1'b0;
            end
            if (wb_bus.stb) begin
                cur_stb++;
                if (cur_stb == 1) begin
                    first_adr = wb_bus.adr;
                    first_dat = wb_bus.dat;
                end else if (wb_bus.adr !== first_adr || wb_bus.dat !== first_dat) begin
                    stable_ok = 1'b0;
                end
                if (stall_budget > 0) begin
                    wb_bus.stall = 1'b1;
                    stall_budget--;
                end else begin
                    wb_bus.stall = 1'b0;
                    acc = 1'b1;
                    if (n_writes < 16) begin
                        log_adr[n_writes] = wb_bus.adr;
                        log_dat[n_writes] = wb_bus.dat;
                        log_sel[n_writes] = wb_bus.sel;
                    end
                    last_stb = cur_stb;
                    n_writes++;
                end
            end else begin
                wb_bus.stall = 1'b0;
                cur_stb = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_acks(input int n);
        int t = 0;
        while (n_acks < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val("ack_wait", 64'(n_acks >= n), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_bus",   64'({wb_bus.cyc, wb_bus.stb, wb_bus.we, wb_bus.sel}), 64'(0));
        check_val("rst_adr",   64'({wb_bus.adr, wb_bus.dat}), 64'(0));
        check_val("rst_flags", 64'({busy, done, frame_err, overrun, bus_err}), 64'(0));
        check_val("rst_cnt",   64'(word_cnt), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // one-cycle low glitch is rejected as a false start
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check_val("glitch_flags",  64'({frame_err, overrun, bus_err}), 64'(0));
        check_val("glitch_writes", 64'(n_writes), 64'(0));

        // word 0 with a framing-error byte after the first good byte
        send_byte(8'h78);
        check_val("busy_rx", 64'(busy), 64'(1));
        send_byte(8'hAA, 1'b0);
        check_val("frame_err", 64'(frame_err), 64'(1));
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        wait_acks(1);
        check_val("w0_count", 64'(n_writes), 64'(1));
        check_val("w0_adr",   64'(log_adr[0]), 64'(32'h1D00));
        check_val("w0_dat",   64'(log_dat[0]), 64'(32'h1234_5678));
        check_val("w0_sel",   64'(log_sel[0]), 64'(4'hF));
        check_val("w0_stb_cycles", 64'(last_stb), 64'(1));
        check_val("w0_cyc_cycles", 64'(last_cyc), 64'(2));
        check_val("w0_word_cnt",   64'(word_cnt), 64'(1));
        check_val("w0_done",  64'(done), 64'(0));

        // word 1 against a slave stalling 3 cycles
        stall_budget = 3;
        stable_ok = 1'b1;
        send_word(32'hDEAD_BEEF);
        wait_acks(2);
        check_val("w1_adr",   64'(log_adr[1]), 64'(32'h1D04));
        check_val("w1_dat",   64'(log_dat[1]), 64'(32'hDEAD_BEEF));
        check_val("w1_stb_cycles", 64'(last_stb), 64'(4));
        check_val("w1_stable", 64'(stable_ok), 64'(1));
        check_val("w1_acks",  64'(n_acks), 64'(2));
        check_val("w1_word_cnt", 64'(word_cnt), 64'(2));
        check_val("done_busy", 64'({done, busy}), 64'(2'b10));

        // bytes after done are ignored
        send_byte(8'h55);
        repeat (10) @(negedge clk);
        check_val("post_done_writes", 64'(n_writes), 64'(2));
        check_val("post_done_cyc", 64'(wb_bus.cyc), 64'(0));

        // reset while the write waits for ack
        do_reset();
        check_val("rst2_done", 64'({done, word_cnt}), 64'(0));
        hold_ack = 1'b1;
        send_word(32'h4433_2211);
        t = 0;
        while (n_writes < 3 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check_val("bwait_state", 64'({wb_bus.cyc, wb_bus.stb}), 64'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_bus", 64'({wb_bus.cyc, wb_bus.stb}), 64'(0));
        check_val("async_rst_cnt", 64'(word_cnt), 64'(0));
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_word(32'h0403_0201);
        wait_acks(3);
        check_val("w2_adr", 64'(log_adr[3]), 64'(32'h1D00));
        check_val("w2_dat", 64'(log_dat[3]), 64'(32'h0403_0201));
        check_val("w2_word_cnt", 64'(word_cnt), 64'(1));

        // second word completes while the first is still pending, then err
        hold_ack = 1'b1;
        send_word(32'hA4A3_A2A1);
        send_word(32'hB4B3_B2B1);
        check_val("overrun", 64'(overrun), 64'(1));
        check_val("overrun_writes", 64'(n_writes), 64'(5));
        err_resp = 1'b1;
        hold_ack = 1'b0;
        wait_acks(4);
        repeat (10) @(negedge clk);
        check_val("w3_adr", 64'(log_adr[4]), 64'(32'h1D04));
        check_val("w3_dat", 64'(log_dat[4]), 64'(32'hA4A3_A2A1));
        check_val("bus_err", 64'(bus_err), 64'(1));
        check_val("err_cnt_done", 64'({word_cnt, done}), 64'({2'd2, 1'b1}));
        check_val("final_writes", 64'(n_writes), 64'(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
